// File: rtl/mem_bus_arbiter.sv
// Arbitrates the core's single memory bus between instruction fetch and data access.
// Grants are registered in IDLE; bus routing, acknowledges and stalls follow the grant combinationally.
module mem_bus_arbiter #(
    parameter int ADDR_SIZE    = 32,
    parameter int DATA_SIZE    = 32,
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inst_cyc,
    input  logic [ADDR_SIZE-1:0]     inst_addr,
    output logic [DATA_SIZE-1:0]     inst_rd_data,
    output logic                     inst_ack,
    output logic                     inst_err,
    input  logic                     data_cyc,
    input  logic                     data_we,
    input  logic [DATA_SIZE/8-1:0]   data_sel,
    input  logic [ADDR_SIZE-1:0]     data_addr,
    input  logic [DATA_SIZE-1:0]     data_wr_data,
    output logic [DATA_SIZE-1:0]     data_rd_data,
    output logic                     data_ack,
    output logic                     data_err,
    output logic                     bus_cyc,
    output logic                     bus_we,
    output logic [DATA_SIZE/8-1:0]   bus_sel,
    output logic [ADDR_SIZE-1:0]     bus_addr,
    output logic [DATA_SIZE-1:0]     bus_wr_data,
    input  logic [DATA_SIZE-1:0]     bus_rd_data,
    input  logic                     bus_ack,
    output logic                     stall_if,
    output logic                     stall_mem
);

    localparam int SEL_W = DATA_SIZE / 8;
    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e           state_q;
    logic [TMO_W-1:0] tmo_q;
    logic [STV_W-1:0] starve_q;

    logic gnt_inst_s;
    logic gnt_data_s;
    logic gnt_cyc_s;
    logic ack_s;
    logic err_s;

    // Grant qualification; reset masks the grant so an aborted transfer never forwards ack/err
    always_comb begin
        gnt_inst_s = reset && (state_q == INST);
        gnt_data_s = reset && (state_q == DATA);
        gnt_cyc_s  = (gnt_inst_s && inst_cyc) || (gnt_data_s && data_cyc);
        ack_s      = gnt_cyc_s && bus_ack;
        err_s      = gnt_cyc_s && !bus_ack && (tmo_q == TMO_LAST);
    end

    // Bus routing from the granted requester plus ack/err/stall forwarding
    always_comb begin
        bus_cyc      = 1'b0;
        bus_we       = 1'b0;
        bus_sel      = {SEL_W{1'b0}};
        bus_addr     = {ADDR_SIZE{1'b0}};
        bus_wr_data  = {DATA_SIZE{1'b0}};
        inst_rd_data = {DATA_SIZE{1'b0}};
        data_rd_data = {DATA_SIZE{1'b0}};
        inst_ack     = 1'b0;
        inst_err     = 1'b0;
        data_ack     = 1'b0;
        data_err     = 1'b0;
        if (gnt_inst_s) begin
            bus_cyc      = inst_cyc && !err_s;
            bus_sel      = {SEL_W{1'b1}};
            bus_addr     = inst_addr;
            inst_rd_data = bus_rd_data;
            inst_ack     = ack_s;
            inst_err     = err_s;
        end else if (gnt_data_s) begin
            bus_cyc      = data_cyc && !err_s;
            bus_we       = data_we;
            bus_sel      = data_sel;
            bus_addr     = data_addr;
            bus_wr_data  = data_wr_data;
            data_rd_data = bus_rd_data;
            data_ack     = ack_s;
            data_err     = err_s;
        end else begin
            bus_cyc = 1'b0;
        end
        stall_if  = inst_cyc && !inst_ack && !inst_err;
        stall_mem = data_cyc && !data_ack && !data_err;
    end

    // Arbitration FSM with watchdog and fetch-starvation counters
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            tmo_q    <= {TMO_W{1'b0}};
            starve_q <= {STV_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    tmo_q <= {TMO_W{1'b0}};
                    if ((starve_q == STARVE_MAX) && inst_cyc) begin
                        state_q  <= INST;
                        starve_q <= {STV_W{1'b0}};
                    end else if (data_cyc) begin
                        state_q <= DATA;
                        if (!inst_cyc) begin
                            starve_q <= {STV_W{1'b0}};
                        end else if (starve_q != STARVE_MAX) begin
                            starve_q <= starve_q + 1'b1;
                        end else begin
                            starve_q <= starve_q;
                        end
                    end else if (inst_cyc) begin
                        state_q  <= INST;
                        starve_q <= {STV_W{1'b0}};
                    end else begin
                        state_q <= IDLE;
                    end
                end
                INST, DATA: begin
                    // A withdrawn request (flush), an ack or a watchdog expiry all end the grant
                    if (!gnt_cyc_s || ack_s || err_s) begin
                        state_q <= IDLE;
                        tmo_q   <= {TMO_W{1'b0}};
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tmo_q   <= {TMO_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter: expected completions are queued as requests are
// raised and checked by a negedge monitor; each task also checks its own cycle-level details.
module tb_mem_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        inst_cyc;
    logic [31:0] inst_addr;
    logic [31:0] inst_rd_data;
    logic        inst_ack;
    logic        inst_err;
    logic        data_cyc;
    logic        data_we;
    logic [3:0]  data_sel;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [31:0] data_rd_data;
    logic        data_ack;
    logic        data_err;
    logic        bus_cyc;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_ack;
    logic        stall_if;
    logic        stall_mem;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_data;
        logic        err;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_e;
    logic [31:0] mon_rd;

    mem_bus_arbiter #(
        .ADDR_SIZE(32), .DATA_SIZE(32), .TIMEOUT(255), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset(reset),
        .inst_cyc(inst_cyc), .inst_addr(inst_addr), .inst_rd_data(inst_rd_data),
        .inst_ack(inst_ack), .inst_err(inst_err),
        .data_cyc(data_cyc), .data_we(data_we), .data_sel(data_sel), .data_addr(data_addr),
        .data_wr_data(data_wr_data), .data_rd_data(data_rd_data),
        .data_ack(data_ack), .data_err(data_err),
        .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_ack(bus_ack),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, got timeout required completion");
        $fatal(1, "bench watchdog expired");
    end

    // Scoreboard: every forwarded ack/err must match the oldest queued expectation
    always @(negedge clock) begin
        if (inst_ack || inst_err || data_ack || data_err) begin
            checks++;
            if ((inst_ack || inst_err) && (data_ack || data_err)) begin
                errors++;
                $display("FAIL both_ports_respond got inst=%0b data=%0b required one port", inst_ack, data_ack);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp got ack/err at addr %h required none", bus_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if ({data_ack || data_err, inst_err || data_err} !== {mon_e.is_data, mon_e.err}) begin
                    errors++;
                    $display("FAIL resp_kind got data=%0b err=%0b required data=%0b err=%0b",
                             data_ack || data_err, inst_err || data_err, mon_e.is_data, mon_e.err);
                end
                if (!mon_e.err) begin
                    checks++;
                    if ({bus_we, bus_sel, bus_addr, bus_wr_data} !== {mon_e.we, mon_e.sel, mon_e.addr, mon_e.wdata}) begin
                        errors++;
                        $display("FAIL bus_fields got we=%0b sel=%h addr=%h wd=%h required we=%0b sel=%h addr=%h wd=%h",
                                 bus_we, bus_sel, bus_addr, bus_wr_data, mon_e.we, mon_e.sel, mon_e.addr, mon_e.wdata);
                    end
                    checks++;
                    mon_rd = mon_e.is_data ? data_rd_data : inst_rd_data;
                    if (mon_rd !== mon_e.rdata) begin
                        errors++;
                        $display("FAIL rd_data got %h required %h", mon_rd, mon_e.rdata);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic push_txn(input logic is_data, input logic err, input logic we, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
        txn_t t;
        t.is_data = is_data; t.err = err; t.we = we; t.sel = sel;
        t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        exp_q.push_back(t);
    endtask

    task automatic test_reset();
        reset = 1'b0; inst_cyc = 1'b1; data_cyc = 1'b1; inst_addr = 32'h0000_0040;
        data_we = 1'b1; data_sel = 4'hF; data_addr = 32'h0000_0080; data_wr_data = 32'h1234_5678;
        bus_rd_data = 32'h0; bus_ack = 1'b0;
        next_cycle();
        settle();
        checks++;
        if ({bus_cyc, bus_we, bus_sel, bus_addr, bus_wr_data} !== 70'd0) begin
            errors++;
            $display("FAIL rst_bus got cyc=%0b addr=%h required all zero", bus_cyc, bus_addr);
        end
        checks++;
        if ({stall_if, stall_mem, inst_ack, data_ack, inst_err, data_err} !== 6'b110000) begin
            errors++;
            $display("FAIL rst_stall got %b required 110000", {stall_if, stall_mem, inst_ack, data_ack, inst_err, data_err});
        end
        checks++;
        if ({dut.tmo_q, dut.starve_q} !== 11'd0) begin
            errors++;
            $display("FAIL rst_counters got tmo=%0d starve=%0d required 0", dut.tmo_q, dut.starve_q);
        end
        inst_cyc = 1'b0; data_cyc = 1'b0; data_we = 1'b0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_fetch();
        inst_cyc = 1'b1; inst_addr = 32'h0000_0100;
        push_txn(1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h0000_0013);
        settle();
        checks++;
        if ({bus_cyc, stall_if} !== 2'b01) begin
            errors++;
            $display("FAIL fetch_req_cycle got cyc=%0b stall_if=%0b required 0 1", bus_cyc, stall_if);
        end
        next_cycle();
        settle();
        checks++;
        if ({bus_cyc, bus_we, bus_addr, stall_if, inst_ack} !== {1'b1, 1'b0, 32'h0000_0100, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fetch_grant got cyc=%0b we=%0b addr=%h stall=%0b ack=%0b required 1 0 00000100 1 0",
                     bus_cyc, bus_we, bus_addr, stall_if, inst_ack);
        end
        next_cycle();
        settle();
        checks++;
        if ({stall_if, inst_ack} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_wait got stall=%0b ack=%0b required 1 0", stall_if, inst_ack);
        end
        next_cycle();
        bus_ack = 1'b1; bus_rd_data = 32'h0000_0013;
        settle();
        checks++;
        if ({inst_ack, stall_if, inst_rd_data} !== {1'b1, 1'b0, 32'h0000_0013}) begin
            errors++;
            $display("FAIL fetch_ack got ack=%0b stall=%0b rd=%h required 1 0 00000013", inst_ack, stall_if, inst_rd_data);
        end
        next_cycle();
        inst_cyc = 1'b0; bus_ack = 1'b0;
        settle();
        checks++;
        if ({bus_cyc, inst_ack, inst_rd_data} !== 34'd0) begin
            errors++;
            $display("FAIL fetch_idle_after got cyc=%0b ack=%0b rd=%h required 0", bus_cyc, inst_ack, inst_rd_data);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        inst_cyc = 1'b1; inst_addr = 32'h0000_0104;
        data_cyc = 1'b1; data_we = 1'b1; data_sel = 4'hF; data_addr = 32'h0000_2000; data_wr_data = 32'hDEAD_BEEF;
        push_txn(1'b1, 1'b0, 1'b1, 4'hF, 32'h0000_2000, 32'hDEAD_BEEF, 32'h1111_1111);
        push_txn(1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 32'h2222_2222);
        settle();
        next_cycle();
        bus_ack = 1'b1; bus_rd_data = 32'h1111_1111;
        settle();
        checks++;
        if ({bus_we, bus_wr_data, bus_addr, stall_if, inst_ack} !== {1'b1, 32'hDEAD_BEEF, 32'h0000_2000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL contend_data_first got we=%0b wd=%h addr=%h stall_if=%0b required 1 deadbeef 00002000 1",
                     bus_we, bus_wr_data, bus_addr, stall_if);
        end
        next_cycle();
        data_cyc = 1'b0; data_we = 1'b0; bus_ack = 1'b0;
        settle();
        checks++;
        if ({bus_cyc, stall_if} !== 2'b01) begin
            errors++;
            $display("FAIL contend_gap got cyc=%0b stall_if=%0b required 0 1", bus_cyc, stall_if);
        end
        next_cycle();
        bus_ack = 1'b1; bus_rd_data = 32'h2222_2222;
        settle();
        checks++;
        if ({inst_ack, bus_addr} !== {1'b1, 32'h0000_0104}) begin
            errors++;
            $display("FAIL contend_fetch_second got ack=%0b addr=%h required 1 00000104", inst_ack, bus_addr);
        end
        next_cycle();
        inst_cyc = 1'b0; bus_ack = 1'b0;
        next_cycle();
    endtask

    task automatic test_starvation();
        int  ndata = 0;
        logic got_inst = 1'b0;
        logic bump = 1'b0;
        inst_cyc = 1'b1; inst_addr = 32'h0000_0200;
        data_cyc = 1'b1; data_we = 1'b0; data_sel = 4'h3; data_addr = 32'h0000_3000; data_wr_data = 32'h0;
        bus_ack = 1'b1; bus_rd_data = 32'hCAFE_0000;
        for (int k = 0; k < 4; k++)
            push_txn(1'b1, 1'b0, 1'b0, 4'h3, 32'h0000_3000 + 32'(4 * k), 32'h0, 32'hCAFE_0000);
        push_txn(1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'hCAFE_0000);
        for (int c = 0; c < 40 && !got_inst; c++) begin
            next_cycle();
            if (bump) data_addr = 32'h0000_3000 + 32'(4 * ndata);
            bump = 1'b0;
            settle();
            if (data_ack) begin ndata++; bump = 1'b1; end
            if (inst_ack) got_inst = 1'b1;
        end
        next_cycle();
        inst_cyc = 1'b0; data_cyc = 1'b0; bus_ack = 1'b0;
        settle();
        checks++;
        if (ndata !== 4 || got_inst !== 1'b1) begin
            errors++;
            $display("FAIL starve_grants got data=%0d inst=%0b required 4 1", ndata, got_inst);
        end
        checks++;
        if (dut.starve_q !== 3'd0) begin
            errors++;
            $display("FAIL starve_clear got %0d required 0", dut.starve_q);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        int   n = 0;
        logic err_cyc = 1'b1;
        logic ack_seen = 1'b0;
        logic first_cyc = 1'b0;
        data_cyc = 1'b1; data_we = 1'b0; data_sel = 4'hF; data_addr = 32'h0000_4000; bus_ack = 1'b0;
        push_txn(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_4000, 32'h0, 32'h0);
        settle();
        for (int k = 1; k <= 300; k++) begin
            next_cycle();
            settle();
            if (k == 1) first_cyc = bus_cyc;
            if (data_ack) ack_seen = 1'b1;
            if (data_err) begin n = k; err_cyc = bus_cyc; break; end
        end
        checks++;
        if (n !== 255 || first_cyc !== 1'b1) begin
            errors++;
            $display("FAIL timeout_cycle got err at %0d granted=%0b required 255 1", n, first_cyc);
        end
        checks++;
        if (err_cyc !== 1'b0 || ack_seen !== 1'b0) begin
            errors++;
            $display("FAIL timeout_bus got cyc=%0b ack_seen=%0b required 0 0", err_cyc, ack_seen);
        end
        next_cycle();
        settle();
        checks++;
        if ({bus_cyc, data_err, stall_mem} !== 3'b001) begin
            errors++;
            $display("FAIL timeout_idle got cyc=%0b err=%0b stall=%0b required 0 0 1", bus_cyc, data_err, stall_mem);
        end
        next_cycle();
        data_cyc = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_ack_on_edge();
        logic early = 1'b0;
        inst_cyc = 1'b1; inst_addr = 32'h0000_0500; bus_ack = 1'b0;
        push_txn(1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_0500, 32'h0, 32'h0000_0077);
        settle();
        for (int k = 1; k <= 254; k++) begin
            next_cycle();
            settle();
            if (inst_ack || inst_err) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL edge_early got response=%0b required 0", early);
        end
        next_cycle();
        bus_ack = 1'b1; bus_rd_data = 32'h0000_0077;
        settle();
        checks++;
        if ({inst_ack, inst_err, bus_cyc} !== 3'b101) begin
            errors++;
            $display("FAIL edge_ack_wins got ack=%0b err=%0b cyc=%0b required 1 0 1", inst_ack, inst_err, bus_cyc);
        end
        next_cycle();
        inst_cyc = 1'b0; bus_ack = 1'b0;
        next_cycle();
    endtask

    task automatic test_withdraw_reset();
        inst_cyc = 1'b1; inst_addr = 32'h0000_0600;
        next_cycle();
        settle();
        checks++;
        if (bus_cyc !== 1'b1) begin
            errors++;
            $display("FAIL wd_grant got cyc=%0b required 1", bus_cyc);
        end
        next_cycle();
        inst_cyc = 1'b0;
        settle();
        next_cycle();
        bus_ack = 1'b1; bus_rd_data = 32'h0000_0099;
        settle();
        checks++;
        if ({inst_ack, inst_err, bus_cyc, inst_rd_data} !== 35'd0) begin
            errors++;
            $display("FAIL wd_late_ack got ack=%0b cyc=%0b rd=%h required 0", inst_ack, bus_cyc, inst_rd_data);
        end
        next_cycle();
        bus_ack = 1'b0;
        data_cyc = 1'b1; data_we = 1'b1; data_sel = 4'hC; data_addr = 32'h0000_7000; data_wr_data = 32'h0000_1234;
        next_cycle();
        next_cycle();
        settle();
        checks++;
        if ({bus_cyc, bus_addr} !== {1'b1, 32'h0000_7000}) begin
            errors++;
            $display("FAIL rst_mid_grant got cyc=%0b addr=%h required 1 00007000", bus_cyc, bus_addr);
        end
        next_cycle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        settle();
        checks++;
        if ({bus_cyc, bus_we, bus_sel, bus_addr, bus_wr_data, data_ack, data_err} !== 72'd0) begin
            errors++;
            $display("FAIL rst_mid_bus got cyc=%0b we=%0b addr=%h required all zero", bus_cyc, bus_we, bus_addr);
        end
        checks++;
        if ({dut.tmo_q, dut.starve_q} !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid_counters got tmo=%0d starve=%0d required 0", dut.tmo_q, dut.starve_q);
        end
        data_cyc = 1'b0; data_we = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_timeout();
        test_ack_on_edge();
        test_withdraw_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the core's single memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage).
- Grants one requester at a time and forwards acknowledges back to it.
- Drives stall_if/stall_mem into the hazard unit while a requester waits.
- A watchdog terminates hung transactions with an error that feeds the exception path (HazardException flush).

Parameters:
- ADDR_SIZE, 32, address width.
- DATA_SIZE, 32, data width; byte-select width is DATA_SIZE/8.
- TIMEOUT, 255, max cycles a granted transaction waits for ack before error; must be >= 2.
- STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced in; must be >= 1.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- inst_cyc  input  1  fetch request; held until inst_ack/inst_err.
- inst_addr  input  ADDR_SIZE  fetch address.
- inst_rd_data  output  DATA_SIZE  fetched word (bus_rd_data when granted, else 0).
- inst_ack  output  1  fetch complete.
- inst_err  output  1  fetch timed out (1 cycle).
- data_cyc  input  1  data request; held until data_ack/data_err.
- data_we  input  1  store when 1, load when 0.
- data_sel  input  DATA_SIZE/8  byte enables.
- data_addr  input  ADDR_SIZE  data address.
- data_wr_data  input  DATA_SIZE  store data.
- data_rd_data  output  DATA_SIZE  load data (bus_rd_data when granted, else 0).
- data_ack  output  1  data access complete.
- data_err  output  1  data access timed out (1 cycle).
- bus_cyc  output  1  bus request.
- bus_we  output  1  bus write enable.
- bus_sel  output  DATA_SIZE/8  bus byte enables.
- bus_addr  output  ADDR_SIZE  bus address.
- bus_wr_data  output  DATA_SIZE  bus write data.
- bus_rd_data  input  DATA_SIZE  bus read data.
- bus_ack  input  1  bus acknowledge.
- stall_if  output  1  fetch waiting.
- stall_mem  output  1  data access waiting.

Behaviour:
- FSM states: IDLE, INST, DATA. Reset (reset==0 at clock edge) gives:
  - state=IDLE, timeout counter=0, starve counter=0.
  - all outputs 0 except stall_if=inst_cyc and stall_mem=data_cyc, which stay combinational.
- Reset mid-transaction aborts the transaction with no ack/err forwarded.
- Arbitration happens in IDLE only, registered (grant visible the cycle after the request is seen).
  - If starve==STARVE_LIMIT and inst_cyc: go INST.
  - Else if data_cyc: go DATA (data has priority as the older instruction).
  - Else if inst_cyc: go INST.
  - Else stay IDLE.
- Starve counter:
  - On a DATA grant with inst_cyc=1: increment, saturating at STARVE_LIMIT.
  - On an INST grant: clear.
  - On a DATA grant with inst_cyc=0: clear.
- Bus outputs are combinational from the granted requester.
  - INST: bus_cyc=inst_cyc, bus_we=0, bus_sel=all ones, bus_addr=inst_addr, bus_wr_data=0.
  - DATA: bus_cyc=data_cyc plus that port's fields.
  - IDLE: everything 0.
- Ack forwarding is combinational: granted_ack = bus_ack && granted cyc. The non-granted ack/err is always 0.
- On granted ack: return to IDLE next cycle, which gives one idle cycle between back-to-back transactions.
- Timeout counter:
  - Cleared on entering INST/DATA; increments each cycle without ack.
  - When the counter equals TIMEOUT-1 and bus_ack=0: assert granted err for that cycle, force bus_cyc=0 that cycle, go IDLE.
  - bus_ack and timeout in the same cycle: ack wins, no err.
- Withdrawal: if the granted requester drops cyc before ack (pipeline flush), go IDLE next cycle. No ack/err is forwarded; a late bus_ack in IDLE is ignored.
- Stalls (combinational):
  - stall_if = inst_cyc && !inst_ack && !inst_err.
  - stall_mem = data_cyc && !data_ack && !data_err.
- Simultaneous requests are serialized with no data loss: each requester's bus fields are used only while it is granted.

Test Plan:
- Single fetch: inst_cyc=1, inst_addr=0x100, bus_ack after 2 cycles with bus_rd_data=0x00000013 -> bus_addr=0x100, bus_we=0, inst_ack=1 with inst_rd_data=0x13 in the ack cycle, stall_if high until ack, state IDLE next cycle.
- Contention: inst_cyc and data_cyc (store, addr 0x2000, sel 0xF, wr_data 0xDEADBEEF) rise the same cycle, bus acks in 1 cycle -> data served first (bus_we=1, bus_wr_data=0xDEADBEEF), then fetch after one IDLE cycle; stall_if high throughout the data transaction.
- Starvation: inst_cyc held while data_cyc re-requests continuously, STARVE_LIMIT=4 -> exactly 4 data grants, then fetch granted, starve counter 0 afterwards.
- Timeout: data load, bus_ack never asserted, TIMEOUT=255 -> data_err=1 exactly 255 cycles after the grant, bus_cyc=0 that cycle, data_ack never 1, arbiter IDLE next cycle.
- Withdrawal/reset: fetch granted, inst_cyc drops after 1 cycle, bus_ack arrives 1 cycle later -> inst_ack stays 0, state IDLE. Separately, reset=0 mid data transaction -> next cycle all bus outputs 0 and counters 0.
- Ack on timeout edge: bus_ack arrives exactly at counter TIMEOUT-1 -> ack forwarded, err stays 0.
